// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   - Active-low segment patterns (gfedcba) for BCD digits 0..9
//   - All-dark segment/dp constant
//   - Scan FSM state encoding
//   - clog2 helper for sizing counters and index buses
package seg_scan_ctrl_pkg;

  // Full 8-bit {dp,g..a} pattern with everything off.
  localparam logic [7:0] SEG_OFF   = 8'hFF;
  // g..a with every segment off; also the decoder output for codes A-F.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/BCDtoSEG.sv
// BCD to seven-segment decoder, common-anode (active-low) outputs.
//   bcd : 4-bit BCD code; codes A-F decode to all segments off
//   seg : {g,f,e,d,c,b,a}, 0 = segment lit
// Purely combinational; the caller registers the result.
module BCDtoSEG
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// One digit is lit per slot; each slot begins with a short all-dark
// interval to prevent ghosting. Inputs are snapshotted once per frame so a
// frame never mixes old and new values.
//   clk, rst    : clock, synchronous active-high reset
//   en          : 1 = scanning, 0 = display dark
//   digits_in   : packed BCD, digit i at [4i+3:4i], digit 0 rightmost
//   dp_in       : per-digit decimal point, 1 = lit
//   blank_lz    : 1 = suppress leading zeros
//   blink_mask  : per-digit blink enable
//   AN          : anodes, active-low, registered
//   SEG         : {dp,g..a}, active-low, registered
//   digit_idx   : digit currently driven on AN (registered, aligned with AN)
//   frame_tick  : one-cycle pulse when a new frame (and snapshot) starts
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500,
  parameter int BLINK_DIV  = 25000000,
  localparam int IDX_W     = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [7:0]              SEG,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int CNT_W   = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // ---------------------------------------------------------------- state
  scan_state_t             state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    snap_load;
  logic                    tick_next;

  logic [4*NUM_DIGITS-1:0] digits_snap_reg;
  logic [NUM_DIGITS-1:0]   dp_snap_reg;
  logic                    lz_snap_reg;
  logic [NUM_DIGITS-1:0]   blink_snap_reg;

  logic [BLINK_W-1:0]      blink_cnt_reg;
  logic                    blink_on_reg;

  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic [7:0]              seg_reg, seg_next;
  logic [IDX_W-1:0]        digit_idx_reg;
  logic                    frame_tick_reg;

  // ------------------------------------------------------ FSM next state
  // The slot counter runs across both BLANK and SHOW, so a slot is always
  // exactly SCAN_DIV cycles: BLANK covers counts 0..BLANK_CYC-1.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    idx_next   = idx_reg;
    snap_load  = 1'b0;
    tick_next  = 1'b0;
    if (!en) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      idx_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_BLANK;
          cnt_next   = '0;
          idx_next   = '0;
          snap_load  = 1'b1;
          tick_next  = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_reg == BLANK_LAST) state_next = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_reg == CNT_LAST) begin
            state_next = ST_BLANK;
            cnt_next   = '0;
            if (idx_reg == IDX_LAST) begin
              idx_next  = '0;
              snap_load = 1'b1;
              tick_next = 1'b1;
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          idx_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      idx_reg         <= '0;
      digits_snap_reg <= '0;
      dp_snap_reg     <= '0;
      lz_snap_reg     <= 1'b0;
      blink_snap_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      if (snap_load) begin
        digits_snap_reg <= digits_in;
        dp_snap_reg     <= dp_in;
        lz_snap_reg     <= blank_lz;
        blink_snap_reg  <= blink_mask;
      end
    end
  end

  // ------------------------------------------------------- blink timebase
  // Free-running while enabled; dropping en restarts it in the ON phase.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= 1'b1;
    end else if (blink_cnt_reg == BLINK_LAST) begin
      blink_cnt_reg <= '0;
      blink_on_reg  <= ~blink_on_reg;
    end else begin
      blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
    end
  end

  // ------------------------------------------- leading-zero suppression
  // Digit gi (gi > 0) is suppressed when it and every digit above it is
  // zero. Digit 0 always shows, so an all-zero value still reads "0".
  logic [3:0]            digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] suppress;

  assign suppress[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = digits_snap_reg[4*gi +: 4];
      if (gi > 0) begin : g_lz
        assign suppress[gi] = lz_snap_reg &&
                              (digits_snap_reg[4*NUM_DIGITS-1 : 4*gi] == '0);
      end
    end
  endgenerate

  // --------------------------------------------------- shared datapath
  // 4'hF decodes to all segments off, which is how suppression blanks a
  // digit while leaving its decimal point under dp control.
  logic [3:0] dec_bcd;
  logic [6:0] dec_seg;
  logic       blink_hide;

  assign dec_bcd    = suppress[idx_reg] ? 4'hF : digit_arr[idx_reg];
  assign blink_hide = !blink_on_reg && blink_snap_reg[idx_reg];

  BCDtoSEG u_dec (
    .bcd (dec_bcd),
    .seg (dec_seg)
  );

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign an_next[gi] = !((state_reg == ST_SHOW) && (idx_reg == IDX_W'(gi)));
    end
  endgenerate

  // Blink blanks the whole digit including dp; the anode keeps scanning.
  always_comb begin
    seg_next = SEG_OFF;
    if ((state_reg == ST_SHOW) && !blink_hide)
      seg_next = {~dp_snap_reg[idx_reg], dec_seg};
  end

  // ------------------------------------------------------ output regs
  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg         <= '1;
      seg_reg        <= SEG_OFF;
      digit_idx_reg  <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      digit_idx_reg  <= idx_reg;
      frame_tick_reg <= tick_next;
    end
  end

  assign AN         = an_reg;
  assign SEG        = seg_reg;
  assign digit_idx  = digit_idx_reg;
  assign frame_tick = frame_tick_reg;

endmodule
